// File: rtl/vga_timing_monitor.sv
// vga_timing_monitor: receive-side VGA raster checker. Measures line/frame geometry
// on pixel-enable samples, declares lock after stable frames and flags timing faults.
//
// state  | meaning
// SEARCH | waiting for a vsync leading edge, all counters held clear
// FIRST  | accumulating the first frame, nothing latched to compare against
// TRACK  | each frame compared with the previous one, lock tracked
module vga_timing_monitor #(
  parameter bit SYNC_ACT_LOW = 1'b1,
  parameter int LOCK_FRAMES  = 2,
  parameter int TIMEOUT      = 1048575
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clk_en,
  input  logic        hsync,
  input  logic        vsync,
  input  logic        hblank,
  input  logic        vblank,
  input  logic [3:0]  vga_r,
  input  logic [3:0]  vga_g,
  input  logic [3:0]  vga_b,
  output logic        locked,
  output logic        frame_done,
  output logic [10:0] h_total,
  output logic [10:0] h_active,
  output logic [10:0] v_total,
  output logic [10:0] v_active,
  output logic [19:0] lit_count,
  output logic        timing_err
);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMO    = TW'(TIMEOUT);
  localparam logic [3:0]    LOCK_N = 4'(LOCK_FRAMES);
  localparam logic [10:0]   MAX11  = 11'h7FF;

  typedef enum logic [1:0] {SEARCH, FIRST, TRACK} state_t;
  state_t state, state_n;

  logic        hs_prev, vs_prev, hs_act, vs_act, hs_edge, vs_edge;
  logic        act, lit_px, line_close, same_geom;
  logic [10:0] hcnt, hcnt_n, hact_line, hact_line_n, href, href_n;
  logic [10:0] hact_acc, hact_acc_n, vcnt, vcnt_n, vact, vact_n;
  logic [10:0] c_href, c_hact, vcnt_b, vact_b;
  logic        line_active, line_active_n, have_hedge, have_hedge_n;
  logic        href_v, href_v_n, frame_bad, frame_bad_n, hact_done, hact_done_n;
  logic        c_href_v, c_bad, c_hact_done;
  logic [19:0] lit, lit_n, lit_b;
  logic [TW-1:0] tcnt, tcnt_n;
  logic [3:0]  match_cnt, match_cnt_n, match_inc;
  logic        locked_n, frame_done_n, timing_err_n;
  logic [10:0] h_total_n, h_active_n, v_total_n, v_active_n;
  logic [19:0] lit_count_n;

  function automatic logic [10:0] inc11(input logic [10:0] v, input logic en);
    return (en && v != MAX11) ? v + 11'd1 : v;
  endfunction

  function automatic logic [19:0] inc20(input logic [19:0] v, input logic en);
    return (en && v != 20'hFFFFF) ? v + 20'd1 : v;
  endfunction

  assign hs_act     = SYNC_ACT_LOW ? ~hsync : hsync;
  assign vs_act     = SYNC_ACT_LOW ? ~vsync : vsync;
  assign hs_edge    = clk_en & hs_act & ~hs_prev;
  assign vs_edge    = clk_en & vs_act & ~vs_prev;
  assign act        = ~hblank & ~vblank;
  assign lit_px     = act & ((|vga_r) | (|vga_g) | (|vga_b));
  assign line_close = hs_edge & have_hedge;
  assign match_inc  = (match_cnt == 4'hF) ? match_cnt : match_cnt + 4'd1;

  always_comb begin
    state_n = state;
    hcnt_n = hcnt; hact_line_n = hact_line; line_active_n = line_active; have_hedge_n = have_hedge;
    href_n = href; href_v_n = href_v; frame_bad_n = frame_bad;
    hact_acc_n = hact_acc; hact_done_n = hact_done;
    vcnt_n = vcnt; vact_n = vact; lit_n = lit; tcnt_n = tcnt; match_cnt_n = match_cnt;
    locked_n = locked; frame_done_n = 1'b0; timing_err_n = timing_err;
    h_total_n = h_total; h_active_n = h_active; v_total_n = v_total; v_active_n = v_active;
    lit_count_n = lit_count;
    c_href = href; c_href_v = href_v; c_bad = frame_bad; c_hact = hact_acc; c_hact_done = hact_done;
    vcnt_b = vcnt; vact_b = vact; lit_b = lit;
    same_geom = 1'b0;

    if (clk_en) begin
      // A line closing on the vsync sample still belongs to the frame that is ending.
      if (have_hedge && hcnt == MAX11) c_bad = 1'b1;
      if (line_close) begin
        if (!href_v) begin
          c_href = hcnt; c_href_v = 1'b1;
        end else if (hcnt != href) begin
          c_bad = 1'b1;
        end
        if (line_active && !hact_done) begin
          c_hact = hact_line; c_hact_done = 1'b1;
        end
      end

      if (hs_edge) begin
        hcnt_n = 11'd1; hact_line_n = {10'd0, act}; line_active_n = act; have_hedge_n = 1'b1;
      end else begin
        hcnt_n = inc11(hcnt, 1'b1); hact_line_n = inc11(hact_line, act);
        line_active_n = line_active | act;
      end

      same_geom = (c_href == h_total) && (c_hact == h_active) &&
                  (vcnt == v_total) && (vact == v_active);

      if (vs_edge) begin
        href_n = '0; href_v_n = 1'b0; frame_bad_n = 1'b0; hact_acc_n = '0; hact_done_n = 1'b0;
        vcnt_b = '0; vact_b = '0; lit_b = '0; tcnt_n = '0;
        if (state != SEARCH) begin
          h_total_n = c_href; h_active_n = c_hact; v_total_n = vcnt; v_active_n = vact;
          lit_count_n = lit; frame_done_n = 1'b1;
        end
        case (state)
          SEARCH: state_n = FIRST;
          FIRST: begin
            match_cnt_n = '0; state_n = TRACK;
          end
          TRACK: begin
            if (same_geom && !c_bad) begin
              match_cnt_n = match_inc; locked_n = (match_inc >= LOCK_N);
            end else begin
              match_cnt_n = '0; locked_n = 1'b0; timing_err_n = 1'b1;
            end
          end
          default: state_n = SEARCH;
        endcase
      end else begin
        href_n = c_href; href_v_n = c_href_v; frame_bad_n = c_bad;
        hact_acc_n = c_hact; hact_done_n = c_hact_done;
        tcnt_n = tcnt + TW'(1);
        if (state != SEARCH && tcnt_n == TMO) begin
          locked_n = 1'b0; timing_err_n = 1'b1; match_cnt_n = '0; state_n = SEARCH;
        end
      end

      vcnt_n = inc11(vcnt_b, hs_edge);
      vact_n = inc11(vact_b, act && (hs_edge || !line_active));
      lit_n  = inc20(lit_b, lit_px);
    end

    if (state_n == SEARCH) begin
      hcnt_n = '0; hact_line_n = '0; line_active_n = 1'b0; have_hedge_n = 1'b0;
      href_n = '0; href_v_n = 1'b0; frame_bad_n = 1'b0; hact_acc_n = '0; hact_done_n = 1'b0;
      vcnt_n = '0; vact_n = '0; lit_n = '0; tcnt_n = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= SEARCH;
      hs_prev <= 1'b0; vs_prev <= 1'b0;
      hcnt <= '0; hact_line <= '0; line_active <= 1'b0; have_hedge <= 1'b0;
      href <= '0; href_v <= 1'b0; frame_bad <= 1'b0; hact_acc <= '0; hact_done <= 1'b0;
      vcnt <= '0; vact <= '0; lit <= '0; tcnt <= '0; match_cnt <= '0;
      locked <= 1'b0; frame_done <= 1'b0; timing_err <= 1'b0;
      h_total <= '0; h_active <= '0; v_total <= '0; v_active <= '0; lit_count <= '0;
    end else begin
      state <= state_n;
      if (clk_en) begin
        hs_prev <= hs_act; vs_prev <= vs_act;
      end
      hcnt <= hcnt_n; hact_line <= hact_line_n; line_active <= line_active_n;
      have_hedge <= have_hedge_n;
      href <= href_n; href_v <= href_v_n; frame_bad <= frame_bad_n;
      hact_acc <= hact_acc_n; hact_done <= hact_done_n;
      vcnt <= vcnt_n; vact <= vact_n; lit <= lit_n; tcnt <= tcnt_n; match_cnt <= match_cnt_n;
      locked <= locked_n; frame_done <= frame_done_n; timing_err <= timing_err_n;
      h_total <= h_total_n; h_active <= h_active_n; v_total <= v_total_n;
      v_active <= v_active_n; lit_count <= lit_count_n;
    end
  end
endmodule
